// File: rtl/agc_servo_if.sv
// agc_servo_if: sample stream from the AGC DSP and coefficient load strobes back to it
interface agc_servo_if #(
  parameter int NBITS       = 5,
  parameter int OFFSET_BITS = 12
);
  logic                          valid_i;
  logic signed [NBITS-1:0]       out_i;
  logic                          gt_i;
  logic                          lt_i;
  logic [16:0]                   scale_o;
  logic signed [OFFSET_BITS-1:0] offset_o;
  logic                          ce_scale_o;
  logic                          ce_offset_o;
  logic                          apply_o;
  modport master (
    output valid_i, out_i, gt_i, lt_i,
    input  scale_o, offset_o, ce_scale_o, ce_offset_o, apply_o
  );
  modport slave (
    input  valid_i, out_i, gt_i, lt_i,
    output scale_o, offset_o, ce_scale_o, ce_offset_o, apply_o
  );
endinterface

// File: rtl/agc_servo.sv
// agc_servo: windowed AGC statistics driving scale/offset updates into the DSP coefficient loader
module agc_servo #(
  parameter int NBITS       = 5,
  parameter int WIN_LOG2    = 10,
  parameter int OFFSET_BITS = 12,
  parameter int SCALE_INIT  = 4096,
  parameter int SCALE_MIN   = 256,
  parameter int SCALE_MAX   = 131071,
  parameter int STEP_SHIFT  = 6,
  parameter int OFF_SHIFT   = 4,
  parameter int GT_TARGET   = 2,
  parameter int LT_TARGET   = 8
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         enable_i,
  output logic         busy_o,
  agc_servo_if.slave   bus
);
  localparam int SW = NBITS + WIN_LOG2;
  localparam int CW = WIN_LOG2 + 1;
  localparam int EW = (SW > OFFSET_BITS ? SW : OFFSET_BITS) + 2;
  localparam logic [CW-1:0] LAST = CW'(2**WIN_LOG2 - 1);
  localparam logic [CW-1:0] GT_T = CW'(GT_TARGET);
  localparam logic [CW-1:0] LT_T = CW'(LT_TARGET);
  localparam logic signed [18:0] SMIN = 19'(SCALE_MIN);
  localparam logic signed [18:0] SMAX = 19'(SCALE_MAX);
  localparam logic signed [EW-1:0] OMIN = EW'(-(2**(OFFSET_BITS-1)));
  localparam logic signed [EW-1:0] OMAX = EW'(2**(OFFSET_BITS-1) - 1);
  typedef enum logic [2:0] {IDLE, ACCUM, UPDATE, LOAD, APPLY} state_t;
  state_t                        state_q, state_d;
  logic [1:0]                    rs_q, rs_d;
  logic                          rst_n;
  logic signed [SW-1:0]          sum_q, sum_d;
  logic [CW-1:0]                 gt_q, gt_d, lt_q, lt_d, cnt_q, cnt_d;
  logic [16:0]                   scale_q, scale_d, shr, step, scale_new;
  logic signed [18:0]            scale_tgt;
  logic signed [OFFSET_BITS-1:0] offset_q, offset_d, off_new;
  logic signed [EW-1:0]          off_wide;
  logic                          ce_q, ce_d, apply_q, apply_d, busy_q, busy_d;
  // reset asserts immediately but releases only after two clean clock edges
  assign rs_d  = {rs_q[0], 1'b1};
  assign rst_n = rs_q[1];
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) rs_q <= '0;
    else         rs_q <= rs_d;
  always_comb begin
    shr       = scale_q >> STEP_SHIFT;
    step      = shr == '0 ? 17'd1 : shr;
    scale_tgt = gt_q > GT_T ? $signed(19'(scale_q)) - $signed(19'(step)) :
                lt_q > LT_T ? $signed(19'(scale_q)) + $signed(19'(step)) :
                              $signed(19'(scale_q));
    scale_new = scale_tgt < SMIN ? 17'(SMIN) : scale_tgt > SMAX ? 17'(SMAX) : scale_tgt[16:0];
    off_wide  = EW'(offset_q) - EW'(sum_q >>> OFF_SHIFT);
    off_new   = off_wide < OMIN ? OFFSET_BITS'(OMIN) :
                off_wide > OMAX ? OFFSET_BITS'(OMAX) : off_wide[OFFSET_BITS-1:0];
  end
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    cnt_d    = cnt_q;
    scale_d  = scale_q;
    offset_d = offset_q;
    case (state_q)
      IDLE: begin
        {sum_d, gt_d, lt_d, cnt_d} = '0;
        if (enable_i) state_d = ACCUM;
      end
      ACCUM:
        if (!enable_i) state_d = IDLE;
        else if (bus.valid_i) begin
          sum_d = sum_q + SW'(bus.out_i);
          gt_d  = gt_q + CW'(bus.gt_i);
          lt_d  = lt_q + CW'(bus.lt_i);
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = UPDATE;
        end
      UPDATE: begin
        scale_d  = scale_new;
        offset_d = off_new;
        state_d  = LOAD;
      end
      LOAD: state_d = APPLY;
      APPLY: begin
        {sum_d, gt_d, lt_d, cnt_d} = '0;
        state_d = enable_i ? ACCUM : IDLE;
      end
      default: state_d = IDLE;
    endcase
    ce_d    = state_d == LOAD;
    apply_d = state_d == APPLY;
    busy_d  = state_d == UPDATE || state_d == LOAD || state_d == APPLY;
  end
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      sum_q    <= '0;
      gt_q     <= '0;
      lt_q     <= '0;
      cnt_q    <= '0;
      scale_q  <= 17'(SCALE_INIT);
      offset_q <= '0;
      ce_q     <= 1'b0;
      apply_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
      cnt_q    <= cnt_d;
      scale_q  <= scale_d;
      offset_q <= offset_d;
      ce_q     <= ce_d;
      apply_q  <= apply_d;
      busy_q   <= busy_d;
    end
  assign bus.scale_o     = scale_q;
  assign bus.offset_o    = offset_q;
  assign bus.ce_scale_o  = ce_q;
  assign bus.ce_offset_o = ce_q;
  assign bus.apply_o     = apply_q;
  assign busy_o          = busy_q;
endmodule

// File: doc/agc_servo.md
Name: agc_servo

Overview:
- Closes the AGC loop: consumes the per-sample saturated output and gt/lt flags produced by the AGC scaling DSP.
- Accumulates statistics over a fixed window of samples.
- At each window end, computes a new scale and offset and drives the DSP's two-stage coefficient load (ce_scale/ce_offset, then apply).
- One instance sits beside each AGC DSP channel in the same clock domain.

Parameters:
- NBITS, 5, width of signed sample from the DSP.
- WIN_LOG2, 10, window length = 2^WIN_LOG2 accepted samples.
- OFFSET_BITS, 12, signed offset width (offset_i units, Q8).
- SCALE_INIT, 4096, scale after reset (1.0 in Q12).
- SCALE_MIN, 256, lower scale clamp.
- SCALE_MAX, 131071, upper scale clamp (17-bit unsigned max).
- STEP_SHIFT, 6, scale step = scale>>STEP_SHIFT, minimum 1.
- OFF_SHIFT, 4, offset correction = sum>>>OFF_SHIFT.
- GT_TARGET, 2, gt count above which scale decreases.
- LT_TARGET, 8, lt count above which scale increases.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- enable_i  in  1  servo run enable.
- valid_i  in  1  sample qualifier.
- out_i  in  NBITS  signed DSP output sample.
- gt_i  in  1  sample above upper threshold.
- lt_i  in  1  sample below lower threshold.
- scale_o  out  17  current/next scale, unsigned.
- offset_o  out  OFFSET_BITS  current/next offset, signed.
- ce_scale_o  out  1  load scale into DSP stage 1.
- ce_offset_o  out  1  load offset into DSP stage 1.
- apply_o  out  1  transfer stage 1 to stage 2.
- busy_o  out  1  high in UPDATE/LOAD/APPLY.

Behaviour:
- Reset (async assert, sync deassert internally):
  - scale_o=SCALE_INIT, offset_o=0.
  - ce_scale_o, ce_offset_o, apply_o, busy_o = 0.
  - State IDLE; accumulators and counters cleared.
- States: IDLE, ACCUM, UPDATE, LOAD, APPLY.
- IDLE:
  - enable_i=1 -> ACCUM next cycle, accumulators cleared.
  - No samples accepted while in IDLE.
- ACCUM (sample accepted when valid_i=1):
  - sum += sign-extended out_i; sum width NBITS+WIN_LOG2, cannot overflow.
  - gt_cnt += gt_i; lt_cnt += lt_i; counter width WIN_LOG2+1.
  - Cycle accepting sample number 2^WIN_LOG2 (counted inclusive of that sample) -> UPDATE.
- UPDATE (1 cycle), new values registered:
  - gt_cnt > GT_TARGET: scale -= max(scale>>STEP_SHIFT, 1).
  - Else if lt_cnt > LT_TARGET: scale += max(scale>>STEP_SHIFT, 1).
  - Else scale unchanged. gt has priority over lt.
  - Scale clamped to [SCALE_MIN, SCALE_MAX]; compute in 18+ bits, no wrap.
  - offset_new = offset - (sum>>>OFF_SHIFT), arithmetic shift (floor), saturated to the signed OFFSET_BITS range.
  - scale_o/offset_o take new values at the end of UPDATE.
- LOAD (1 cycle): ce_scale_o = ce_offset_o = 1; scale_o/offset_o stable.
- APPLY (1 cycle): apply_o = 1 -> ACCUM, accumulators cleared.
- Latency: last window sample accepted in cycle N -> ce pulses in N+2 -> apply_o in N+3 -> samples accepted again from N+4.
- busy_o = 1 in UPDATE, LOAD and APPLY. valid_i during those states is discarded, not queued.
- enable_i low during ACCUM:
  - -> IDLE next cycle; partial window discarded; scale_o/offset_o hold.
  - No ce/apply pulses are generated.
- enable_i low during UPDATE/LOAD/APPLY: the sequence completes, then -> IDLE instead of ACCUM.
- scale_o/offset_o change only in UPDATE; outputs are registered.
- ce_* and apply_o are each single-cycle pulses and are never asserted together.

Test Plan:
- Reset with SCALE_INIT=4096 -> scale_o=4096, offset_o=0, all strobes 0. Asserting rstn_i low mid-ACCUM -> same values immediately, asynchronously.
- WIN_LOG2=4, enable, 16 valid samples out_i=+15, gt_i=1:
  - sum=240, correction 15 -> offset_o=-15, scale_o=4032.
  - ce pulses 2 cycles after the 16th sample; apply_o 1 cycle later.
- 16 samples out_i=0, lt_i=1, gt_i=0 -> scale_o=4160, offset_o unchanged. 16 samples with gt_cnt=2, lt_cnt=8 -> no change, but ce/apply still pulse.
- SCALE_INIT=131000, lt-only window -> scale_o clamps to 131071. SCALE_INIT=260, gt-only window -> scale_o=256.
- OFF_SHIFT=0, repeated windows of out_i=+15 -> offset_o steps by -240 per window and saturates at -2048, never wrapping positive.
- Drop enable_i after 8 samples -> no strobes, scale_o/offset_o held. Re-enable -> exactly 16 further samples are required before the next update. valid_i during busy_o=1 is not counted.
